// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the UART stream receiver.
// The RX_PARITY state exists only when UART_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;
`endif

    // Counts data bits 0..DATA_BITS-1 (DATA_BITS <= 9) and stop bits.
    localparam int unsigned BIT_CNT_W = 4;

    function automatic int unsigned calc_divisor(int unsigned clk_hz,
                                                 int unsigned baud,
                                                 int unsigned os);
        return clk_hz / (baud * os);
    endfunction

    function automatic int unsigned cnt_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned mid_sample(int unsigned os);
        return os / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_stream_receiver_if.sv
// Ready/valid byte stream plus FIFO occupancy leaving the UART receiver.
interface uart_stream_if #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned COUNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] data_out;
    logic                 data_out_valid;
    logic                 data_out_ready;
    logic [COUNT_W-1:0]   fifo_count;

    modport master (output data_out, data_out_valid, fifo_count, input data_out_ready);
    modport slave  (input data_out, data_out_valid, fifo_count, output data_out_ready);
endinterface

// File: rtl/stream_sync_fifo.sv
// First-word fall-through synchronous FIFO with ready/valid output,
// occupancy count and a drop-on-full overflow pulse.
module stream_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    output logic [WIDTH-1:0]   data,
    output logic               valid,
    input  logic               ready,
    output logic [$clog2(DEPTH):0] count,
    output logic               overflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             full_c;
    logic             do_push_c;
    logic             do_pop_c;

    assign data = mem[rd_ptr];

    // A full FIFO still accepts a push when the head is leaving in the same cycle.
    always_comb begin
        full_c     = (count == CNT_W'(DEPTH));
        do_pop_c   = valid && ready;
        do_push_c  = push && (!full_c || do_pop_c);
        count_next = count;
        if (do_push_c && !do_pop_c) begin
            count_next = count + CNT_W'(1);
        end else if (!do_push_c && do_pop_c) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            overflow <= push && full_c && !do_pop_c;
            if (do_push_c) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            valid <= (count_next != '0);
        end
    end

endmodule

// File: rtl/uart_stream_receiver.sv
// Oversampling UART receiver feeding a ready/valid stream through a FIFO.
// Define UART_PARITY_EN to add a parity bit check after the data bits.
module uart_stream_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
    parameter int unsigned BAUD_RATE       = 115_200,
    parameter int unsigned OVERSAMPLE      = 16,
    parameter int unsigned DATA_BITS       = 8,
    parameter int unsigned STOP_BITS       = 1,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned PARITY_ODD      = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          uart_receive,
    uart_stream_if.master stream,
    output logic          frame_error,
    output logic          parity_error,
    output logic          overflow
);
    localparam int unsigned DIVISOR    = calc_divisor(CLOCK_FREQUENCY, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned DIV_W      = cnt_width(DIVISOR);
    localparam int unsigned SMP_W      = cnt_width(OVERSAMPLE);
    localparam int unsigned MID_SAMPLE = mid_sample(OVERSAMPLE);

    if (DIVISOR < 1) begin : g_bad_divisor
        $error("uart_stream_receiver: clock too slow for BAUD_RATE*OVERSAMPLE");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_stream_receiver: OVERSAMPLE must be even and >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_stream_receiver: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_stream_receiver: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_stream_receiver: FIFO_DEPTH must be a power of two >= 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_stream_receiver: PARITY_ODD must be 0 or 1");
    end

    logic                 sync_meta;
    logic                 rx;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick_c;
    rx_state_t            state;
    rx_state_t            state_next;
    logic [SMP_W-1:0]     smp_cnt;
    logic [SMP_W-1:0]     smp_next;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] bit_next;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_next;
    logic                 push_c;
    logic                 push_q;
    logic                 frame_err_c;
    logic                 bit_end_c;
`ifdef UART_PARITY_EN
    logic                 par_bad;
    logic                 par_bad_next;
    logic                 parity_err_c;
`endif

    // Two-flop synchronizer; the line idles high.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= 1'b1;
            rx        <= 1'b1;
        end else begin
            sync_meta <= uart_receive;
            rx        <= sync_meta;
        end
    end

    assign tick_c = (div_cnt == DIV_W'(DIVISOR - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
        end
    end

    assign bit_end_c = tick_c && (smp_cnt == SMP_W'(OVERSAMPLE - 1));

    // Next-state logic; every sample after the start bit lands mid-bit.
    always_comb begin
        state_next  = state;
        smp_next    = smp_cnt;
        bit_next    = bit_cnt;
        shift_next  = shift;
        push_c      = 1'b0;
        frame_err_c = 1'b0;
`ifdef UART_PARITY_EN
        par_bad_next = par_bad;
        parity_err_c = 1'b0;
`endif
        if (tick_c && state != RX_IDLE && state != RX_WAIT_HIGH) begin
            smp_next = bit_end_c ? '0 : smp_cnt + SMP_W'(1);
        end
        unique case (state)
            RX_IDLE: begin
                if (!rx) begin
                    smp_next   = '0;
                    state_next = RX_START;
                end
            end
            RX_START: begin
                if (tick_c && smp_cnt == SMP_W'(MID_SAMPLE)) begin
                    smp_next = '0;
                    bit_next = '0;
`ifdef UART_PARITY_EN
                    par_bad_next = 1'b0;
`endif
                    state_next = rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_end_c) begin
                    shift_next = {rx, shift[DATA_BITS-1:1]};
                    if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
                        bit_next = '0;
`ifdef UART_PARITY_EN
                        state_next = RX_PARITY;
`else
                        state_next = RX_STOP;
`endif
                    end else begin
                        bit_next = bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (bit_end_c) begin
                    if (rx != ((^shift) ^ 1'(PARITY_ODD))) begin
                        parity_err_c = 1'b1;
                        par_bad_next = 1'b1;
                    end
                    state_next = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (bit_end_c) begin
                    if (!rx) begin
                        frame_err_c = 1'b1;
                        state_next  = RX_WAIT_HIGH;
                    end else if (bit_cnt == BIT_CNT_W'(STOP_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        push_c = !par_bad;
`else
                        push_c = 1'b1;
`endif
                        state_next = RX_IDLE;
                    end else begin
                        bit_next = bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rx) begin
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RX_IDLE;
            smp_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            push_q      <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            smp_cnt     <= smp_next;
            bit_cnt     <= bit_next;
            shift       <= shift_next;
            push_q      <= push_c;
            frame_error <= frame_err_c;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            par_bad      <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            par_bad      <= par_bad_next;
            parity_error <= parity_err_c;
        end
    end
`else
    assign parity_error = 1'b0;
`endif

    // shift holds the completed byte until the next frame's data bits begin.
    stream_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_q),
        .push_data (shift),
        .data      (stream.data_out),
        .valid     (stream.data_out_valid),
        .ready     (stream.data_out_ready),
        .count     (stream.fifo_count),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_uart_stream_receiver.sv
// Scoreboard bench for uart_stream_receiver (16 MHz, 100 kbaud, x16, 4-deep FIFO).
module tb_uart_stream_receiver;
    localparam int unsigned BIT_CYC = 160;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic line  = 1'b1;
    logic frame_error;
    logic parity_error;
    logic overflow;

    int checks = 0;
    int passes = 0;
    int n_beats = 0;
    int n_frame = 0;
    int n_par = 0;
    int n_ovf = 0;
    logic [7:0] sb[$];

    always #5 clock = ~clock;

    uart_stream_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) sif();

    uart_stream_receiver #(
        .CLOCK_FREQUENCY (16_000_000),
        .BAUD_RATE       (100_000),
        .OVERSAMPLE      (16),
        .DATA_BITS       (8),
        .STOP_BITS       (1),
        .FIFO_DEPTH      (4),
        .PARITY_ODD      (0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .uart_receive (line),
        .stream       (sif),
        .frame_error  (frame_error),
        .parity_error (parity_error),
        .overflow     (overflow)
    );

    // Output monitor: pops the scoreboard on every accepted beat and counts pulses.
    always @(negedge clock) begin
        logic [7:0] exp_byte;
        if (frame_error === 1'b1)  n_frame++;
        if (parity_error === 1'b1) n_par++;
        if (overflow === 1'b1)     n_ovf++;
        if (sif.data_out_valid === 1'b1 && sif.data_out_ready === 1'b1) begin
            n_beats++;
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL beat_unexpected: got %02h, scoreboard empty", sif.data_out);
            end else begin
                exp_byte = sb.pop_front();
                if (sif.data_out !== exp_byte)
                    $display("FAIL beat_data: got %02h expected %02h", sif.data_out, exp_byte);
                else
                    passes++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        line = b;
        cyc(BIT_CYC);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_val);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
        drive_bit((^d) ^ par_flip);
`else
        if (par_flip) line = 1'b1;
`endif
        drive_bit(stop_val);
        line = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        line  = 1'b1;
        sif.data_out_ready = 1'b0;
        cyc(4);
        checks++; if (sif.data_out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", sif.data_out_valid); else passes++;
        checks++; if (sif.fifo_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", sif.fifo_count); else passes++;
        checks++; if (sif.data_out !== 8'h00) $display("FAIL reset_data: got %02h expected 00", sif.data_out); else passes++;
        checks++; if (frame_error !== 1'b0) $display("FAIL reset_frame_error: got %b expected 0", frame_error); else passes++;
        checks++; if (parity_error !== 1'b0) $display("FAIL reset_parity_error: got %b expected 0", parity_error); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else passes++;
        reset = 1'b0;
        cyc(BIT_CYC);
    endtask

    task automatic test_single;
        int b0 = n_beats;
        int f0 = n_frame;
        int p0 = n_par;
        sif.data_out_ready = 1'b1;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b1);
        cyc(40);
        checks++; if (n_beats - b0 != 1) $display("FAIL single_beats: got %0d expected 1", n_beats - b0); else passes++;
        checks++; if (n_frame != f0 || n_par != p0) $display("FAIL single_errors: got frame %0d parity %0d expected 0 0", n_frame - f0, n_par - p0); else passes++;
        checks++; if (sif.fifo_count !== 3'd0) $display("FAIL single_count: got %0d expected 0", sif.fifo_count); else passes++;
    endtask

    task automatic test_back_to_back;
        int b0;
        logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        sif.data_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) sb.push_back(bytes[i]);
        for (int i = 0; i < 4; i++) send_frame(bytes[i], 1'b0, 1'b1);
        cyc(40);
        checks++; if (sif.fifo_count !== 3'd4) $display("FAIL b2b_count: got %0d expected 4", sif.fifo_count); else passes++;
        checks++; if (sif.data_out !== 8'h11) $display("FAIL b2b_head_stable: got %02h expected 11", sif.data_out); else passes++;
        b0 = n_beats;
        sif.data_out_ready = 1'b1;
        cyc(4);
        checks++; if (n_beats - b0 != 4) $display("FAIL b2b_consecutive: got %0d beats in 4 cycles expected 4", n_beats - b0); else passes++;
        checks++; if (sif.data_out_valid !== 1'b0) $display("FAIL b2b_drained: got valid %b expected 0", sif.data_out_valid); else passes++;
    endtask

    task automatic test_overflow;
        int o0 = n_ovf;
        int b0;
        sif.data_out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            sb.push_back(8'(i));
            send_frame(8'(i), 1'b0, 1'b1);
        end
        cyc(20);
        checks++; if (n_ovf != o0) $display("FAIL ovf_early: got %0d pulses expected 0", n_ovf - o0); else passes++;
        send_frame(8'h05, 1'b0, 1'b1);
        cyc(20);
        checks++; if (n_ovf - o0 != 1) $display("FAIL ovf_pulse: got %0d pulses expected 1", n_ovf - o0); else passes++;
        checks++; if (sif.fifo_count !== 3'd4) $display("FAIL ovf_count: got %0d expected 4", sif.fifo_count); else passes++;
        b0 = n_beats;
        sif.data_out_ready = 1'b1;
        cyc(12);
        checks++; if (n_beats - b0 != 4) $display("FAIL ovf_drain: got %0d beats expected 4", n_beats - b0); else passes++;
    endtask

    task automatic test_frame_error;
        int b0 = n_beats;
        int f0 = n_frame;
        sif.data_out_ready = 1'b1;
        send_frame(8'h55, 1'b0, 1'b0);
        cyc(BIT_CYC);
        checks++; if (n_frame - f0 != 1) $display("FAIL frame_pulse: got %0d expected 1", n_frame - f0); else passes++;
        checks++; if (n_beats != b0) $display("FAIL frame_no_push: got %0d beats expected 0", n_beats - b0); else passes++;
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b1);
        cyc(40);
        checks++; if (n_beats - b0 != 1) $display("FAIL frame_recover: got %0d beats expected 1", n_beats - b0); else passes++;
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity;
        int b0 = n_beats;
        int p0 = n_par;
        int f0 = n_frame;
        sif.data_out_ready = 1'b1;
        send_frame(8'h03, 1'b1, 1'b1);
        cyc(40);
        checks++; if (n_par - p0 != 1) $display("FAIL parity_pulse: got %0d expected 1", n_par - p0); else passes++;
        checks++; if (n_beats != b0) $display("FAIL parity_no_push: got %0d beats expected 0", n_beats - b0); else passes++;
        checks++; if (n_frame != f0) $display("FAIL parity_frame: got %0d frame pulses expected 0", n_frame - f0); else passes++;
    endtask
`endif

    task automatic test_glitch;
        int b0 = n_beats;
        int f0 = n_frame;
        sif.data_out_ready = 1'b1;
        line = 1'b0;
        cyc(30);
        line = 1'b1;
        cyc(2 * BIT_CYC);
        checks++; if (n_beats != b0 || n_frame != f0) $display("FAIL glitch_rejected: got beats %0d frame %0d expected 0 0", n_beats - b0, n_frame - f0); else passes++;
        checks++; if (sif.fifo_count !== 3'd0) $display("FAIL glitch_count: got %0d expected 0", sif.fifo_count); else passes++;
        sb.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b1);
        cyc(40);
        checks++; if (n_beats - b0 != 1) $display("FAIL glitch_next_frame: got %0d beats expected 1", n_beats - b0); else passes++;
    endtask

    task automatic test_reset_midframe;
        int b0 = n_beats;
        int f0 = n_frame;
        int p0 = n_par;
        int o0 = n_ovf;
        sif.data_out_ready = 1'b1;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        cyc(40);
        checks++; if (n_beats != b0) $display("FAIL midreset_no_output: got %0d beats expected 0", n_beats - b0); else passes++;
        checks++; if (sif.fifo_count !== 3'd0) $display("FAIL midreset_count: got %0d expected 0", sif.fifo_count); else passes++;
        checks++; if (n_frame != f0 || n_par != p0 || n_ovf != o0) $display("FAIL midreset_pulses: got frame %0d parity %0d overflow %0d expected 0 0 0", n_frame - f0, n_par - p0, n_ovf - o0); else passes++;
        sb.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b1);
        cyc(40);
        checks++; if (n_beats - b0 != 1) $display("FAIL midreset_next_frame: got %0d beats expected 1", n_beats - b0); else passes++;
    endtask

    initial begin
        sif.data_out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_frame_error();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_glitch();
        test_reset_midframe();
        checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size()); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
